// File: rtl/p_hit_arb_pkg.sv
// Shared types for the p_hit request arbiter.
// FSM state encoding and tag width helper.
package p_hit_arb_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic int tag_bits(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

endpackage

// File: rtl/p_hit_tag_fifo.sv
// Tag FIFO: remembers which requester owns each in-flight job.
// Synchronous, first-word-fall-through, power-of-two depth.
module p_hit_tag_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    // Next pointers and storage; the extra pointer bit separates full from empty.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q[AW-1:0]] = push_data;
            wr_d = wr_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_d = rd_q + (AW+1)'(1);
        end
    end

    // Status flags and fall-through head.
    always_comb begin
        empty    = (wr_q == rd_q);
        full     = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop_data = mem_q[rd_q[AW-1:0]];
    end

    // State registers; reset empties the FIFO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/p_hit_arb.sv
// Round-robin arbiter feeding the p_hit pipeline and routing results back.
// Optional per-requester issue counters: define P_HIT_ARB_STATS_EN.
module p_hit_arb
    import p_hit_arb_pkg::*;
#(
    parameter int D_BITS  = 32,
    parameter int N_REQ   = 4,
    parameter int MAX_OUT = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_empty,
    output logic [N_REQ-1:0]         req_rd_en,
    input  logic signed [D_BITS-1:0] req_origin [N_REQ][3],
    input  logic signed [D_BITS-1:0] req_dir [N_REQ][3],
    output logic                     ph_wr_en,
    input  logic                     ph_full,
    output logic signed [D_BITS-1:0] ph_origin [3],
    output logic signed [D_BITS-1:0] ph_dir [3],
    input  logic                     ph_out_empty,
    output logic                     ph_out_rd_en,
    input  logic signed [D_BITS-1:0] ph_p_hit [3],
    output logic [N_REQ-1:0]         resp_wr_en,
    input  logic [N_REQ-1:0]         resp_full,
    output logic signed [D_BITS-1:0] resp_p_hit [3],
    input  logic                     flush,
    output logic                     flush_done,
    output logic [$clog2(MAX_OUT):0] outstanding,
    output logic [31:0]              stat_issued [N_REQ]
);

    localparam int TAG_BITS = tag_bits(N_REQ);
    localparam int OCW      = $clog2(MAX_OUT) + 1;

    state_e              state_q, state_d;
    logic [TAG_BITS-1:0] ptr_q, ptr_d;
    logic [OCW-1:0]      out_q, out_d;
    logic signed [D_BITS-1:0] org_q [3];
    logic signed [D_BITS-1:0] org_d [3];
    logic signed [D_BITS-1:0] dir_q [3];
    logic signed [D_BITS-1:0] dir_d [3];

    logic [TAG_BITS-1:0] cand [N_REQ];
    logic [TAG_BITS-1:0] grant;
    logic                any_req;
    logic                issue;
    logic                retire;
    logic                head_ok;
    logic                tag_full;
    logic                tag_empty;
    logic [TAG_BITS-1:0] tag_head;

    // Round-robin pick: scan from the pointer, first non-empty requester wins.
    always_comb begin
        any_req = 1'b0;
        grant   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand[k] = TAG_BITS'((int'(ptr_q) + k) % N_REQ);
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (!any_req && !req_empty[cand[k]]) begin
                any_req = 1'b1;
                grant   = cand[k];
            end
        end
    end

    // Issue decision, pop strobes and zero-latency data steering.
    always_comb begin
        issue = reset && (state_q == RUN) && !flush && any_req &&
                !ph_full && (out_q < OCW'(MAX_OUT)) && !tag_full;
        ph_wr_en = issue;
        for (int i = 0; i < N_REQ; i++) begin
            req_rd_en[i] = issue && (grant == TAG_BITS'(i));
        end
        ptr_d = ptr_q;
        org_d = org_q;
        dir_d = dir_q;
        if (issue) begin
            ptr_d = TAG_BITS'((int'(grant) + 1) % N_REQ);
            for (int j = 0; j < 3; j++) begin
                org_d[j] = req_origin[grant][j];
                dir_d[j] = req_dir[grant][j];
            end
        end
        ph_origin = org_d;
        ph_dir    = dir_d;
    end

    // In-order retirement; a full head destination blocks everything behind it.
    always_comb begin
        head_ok = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (tag_head == TAG_BITS'(i)) begin
                head_ok = !resp_full[i];
            end
        end
        retire       = !ph_out_empty && !tag_empty && head_ok;
        ph_out_rd_en = retire;
        for (int i = 0; i < N_REQ; i++) begin
            resp_wr_en[i] = retire && (tag_head == TAG_BITS'(i));
        end
        resp_p_hit = ph_p_hit;
    end

    // In-flight job count.
    always_comb begin
        out_d = out_q;
        unique case ({issue, retire})
            2'b10:   out_d = out_q + OCW'(1);
            2'b01:   out_d = out_q - OCW'(1);
            default: out_d = out_q;
        endcase
        outstanding = out_q;
    end

    // Flush FSM; DRAIN looks at the next count so DONE follows the last retire.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (flush) state_d = DRAIN;
            DRAIN:   if (out_d == '0) state_d = DONE;
            DONE:    if (!flush) state_d = RUN;
            default: state_d = RUN;
        endcase
        flush_done = (state_q == DONE);
    end

    // Control and held-data registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            ptr_q   <= '0;
            out_q   <= '0;
            for (int j = 0; j < 3; j++) begin
                org_q[j] <= '0;
                dir_q[j] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            out_q   <= out_d;
            org_q   <= org_d;
            dir_q   <= dir_d;
        end
    end

    p_hit_tag_fifo #(
        .DEPTH (MAX_OUT),
        .W     (TAG_BITS)
    ) u_tag_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (issue),
        .push_data (grant),
        .pop       (retire),
        .pop_data  (tag_head),
        .full      (tag_full),
        .empty     (tag_empty)
    );

`ifdef P_HIT_ARB_STATS_EN
    logic [31:0] stat_q [N_REQ];
    logic [31:0] stat_d [N_REQ];

    // Wrapping per-requester issue counters.
    always_comb begin
        stat_d = stat_q;
        if (issue) begin
            stat_d[grant] = stat_q[grant] + 32'd1;
        end
        stat_issued = stat_q;
    end

    // Counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_REQ; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            stat_q <= stat_d;
        end
    end
`else
    // Statistics disabled: constant zero.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            stat_issued[i] = '0;
        end
    end
`endif

endmodule

// File: tb/tb_p_hit_arb.sv
// Directed bench for p_hit_arb: arbitration, routing, limits, flush, reset.
// Works with or without P_HIT_ARB_STATS_EN defined.
module tb_p_hit_arb;

    localparam int D = 32;
    localparam int N = 4;
    localparam int M = 16;

    logic                clock = 1'b0;
    logic                reset;
    logic [N-1:0]        req_empty;
    logic [N-1:0]        req_rd_en;
    logic signed [D-1:0] req_origin [N][3];
    logic signed [D-1:0] req_dir [N][3];
    logic                ph_wr_en;
    logic                ph_full;
    logic signed [D-1:0] ph_origin [3];
    logic signed [D-1:0] ph_dir [3];
    logic                ph_out_empty;
    logic                ph_out_rd_en;
    logic signed [D-1:0] ph_p_hit [3];
    logic [N-1:0]        resp_wr_en;
    logic [N-1:0]        resp_full;
    logic signed [D-1:0] resp_p_hit [3];
    logic                flush;
    logic                flush_done;
    logic [4:0]          outstanding;
    logic [31:0]         stat_issued [N];

    int checks = 0;
    int errors = 0;

    p_hit_arb #(
        .D_BITS  (D),
        .N_REQ   (N),
        .MAX_OUT (M)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_empty    (req_empty),
        .req_rd_en    (req_rd_en),
        .req_origin   (req_origin),
        .req_dir      (req_dir),
        .ph_wr_en     (ph_wr_en),
        .ph_full      (ph_full),
        .ph_origin    (ph_origin),
        .ph_dir       (ph_dir),
        .ph_out_empty (ph_out_empty),
        .ph_out_rd_en (ph_out_rd_en),
        .ph_p_hit     (ph_p_hit),
        .resp_wr_en   (resp_wr_en),
        .resp_full    (resp_full),
        .resp_p_hit   (resp_p_hit),
        .flush        (flush),
        .flush_done   (flush_done),
        .outstanding  (outstanding),
        .stat_issued  (stat_issued)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic set_idle();
        req_empty    = '1;
        ph_full      = 1'b0;
        ph_out_empty = 1'b1;
        resp_full    = '0;
        flush        = 1'b0;
        for (int j = 0; j < 3; j++) ph_p_hit[j] = '0;
    endtask

    task automatic init_data();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < 3; j++) begin
                req_origin[i][j] = (i + 1) * 32'h100 + j;
                req_dir[i][j]    = -((i + 1) * 16 + j);
            end
        end
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        req_empty    = '0;
        ph_out_empty = 1'b0;
        #2;
        checks++;
        if (ph_wr_en !== 1'b0 || req_rd_en !== 4'b0000) begin
            errors++;
            $display("FAIL rst_issue wr=%b rd=%b exp 0", ph_wr_en, req_rd_en);
        end
        checks++;
        if (ph_out_rd_en !== 1'b0 || resp_wr_en !== 4'b0000 || flush_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_strobes ordr=%b resp=%b fd=%b exp 0",
                     ph_out_rd_en, resp_wr_en, flush_done);
        end
        checks++;
        if (outstanding !== 5'd0 || ph_origin[0] !== 32'sd0 || ph_dir[2] !== 32'sd0) begin
            errors++;
            $display("FAIL rst_state out=%0d org=%0h dir=%0h exp 0",
                     outstanding, ph_origin[0], ph_dir[2]);
        end
        checks++;
        if (stat_issued[0] !== 32'd0) begin
            errors++;
            $display("FAIL rst_stat got %0d exp 0", stat_issued[0]);
        end
        set_idle();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_single();
        req_origin[1][0] = 32'sh10000;
        req_origin[1][1] = 32'sh20000;
        req_origin[1][2] = 32'sh30000;
        req_empty = 4'b1101;
        ph_full   = 1'b1;
        mid();
        checks++;
        if (ph_wr_en !== 1'b0 || req_rd_en !== 4'b0000) begin
            errors++;
            $display("FAIL full_block wr=%b rd=%b exp 0", ph_wr_en, req_rd_en);
        end
        tick();
        ph_full = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mid();
            checks++;
            if (ph_wr_en !== 1'b1 || req_rd_en !== 4'b0010 ||
                ph_origin[0] !== 32'sh10000 || ph_origin[2] !== 32'sh30000 ||
                ph_dir[1] !== -32'sd33) begin
                errors++;
                $display("FAIL single_issue%0d wr=%b rd=%b org0=%0h org2=%0h dir1=%0d exp 1 0010 10000 30000 -33",
                         k, ph_wr_en, req_rd_en, ph_origin[0], ph_origin[2], ph_dir[1]);
            end
            tick();
        end
        req_empty = 4'b1111;
        req_origin[0][0] = 'x;
        req_origin[0][1] = 'x;
        mid();
        checks++;
        if (ph_wr_en !== 1'b0 || ph_origin[0] !== 32'sh10000 ||
            ph_origin[1] !== 32'sh20000 || outstanding !== 5'd3) begin
            errors++;
            $display("FAIL single_hold wr=%b org0=%0h org1=%0h out=%0d exp 0 10000 20000 3",
                     ph_wr_en, ph_origin[0], ph_origin[1], outstanding);
        end
        tick();
        ph_out_empty = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ph_p_hit[0] = 32'(k + 100);
            ph_p_hit[2] = 32'(k + 200);
            mid();
            checks++;
            if (ph_out_rd_en !== 1'b1 || resp_wr_en !== 4'b0010 ||
                resp_p_hit[0] !== 32'(k + 100) || resp_p_hit[2] !== 32'(k + 200)) begin
                errors++;
                $display("FAIL single_ret%0d ordr=%b resp=%b p0=%0d p2=%0d exp 1 0010 %0d %0d",
                         k, ph_out_rd_en, resp_wr_en, resp_p_hit[0], resp_p_hit[2],
                         k + 100, k + 200);
            end
            tick();
        end
        ph_out_empty = 1'b1;
        mid();
        checks++;
        if (outstanding !== 5'd0 || ph_out_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL single_drained out=%0d ordr=%b exp 0 0", outstanding, ph_out_rd_en);
        end
        tick();
        init_data();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp;
        do_reset();
        req_empty = '0;
        for (int k = 0; k < 8; k++) begin
            exp = 4'b0001 << (k % 4);
            mid();
            checks++;
            if (req_rd_en !== exp || ph_origin[0] !== 32'((k % 4 + 1) * 32'h100)) begin
                errors++;
                $display("FAIL rr_grant%0d rd=%b org=%0h exp %b %0h",
                         k, req_rd_en, ph_origin[0], exp, (k % 4 + 1) * 32'h100);
            end
            tick();
        end
        req_empty = '1;
        mid();
        checks++;
        if (outstanding !== 5'd8) begin
            errors++;
            $display("FAIL rr_out got %0d exp 8", outstanding);
        end
        tick();
        ph_out_empty = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp = 4'b0001 << (k % 4);
            mid();
            checks++;
            if (resp_wr_en !== exp) begin
                errors++;
                $display("FAIL rr_route%0d got %b exp %b", k, resp_wr_en, exp);
            end
            tick();
        end
        ph_out_empty = 1'b1;
    endtask

    task automatic test_max_out();
        int cnt;
        do_reset();
        cnt = 0;
        req_empty = 4'b1110;
        for (int k = 0; k < 20; k++) begin
            mid();
            if (ph_wr_en === 1'b1) cnt++;
            tick();
        end
        mid();
        checks++;
        if (cnt != 16 || outstanding !== 5'd16 || ph_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL max_limit issues=%0d out=%0d wr=%b exp 16 16 0",
                     cnt, outstanding, ph_wr_en);
        end
        tick();
        ph_out_empty = 1'b0;
        mid();
        checks++;
        if (ph_out_rd_en !== 1'b1 || ph_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL max_retire ordr=%b wr=%b exp 1 0", ph_out_rd_en, ph_wr_en);
        end
        tick();
        ph_out_empty = 1'b1;
        mid();
        checks++;
        if (ph_wr_en !== 1'b1 || outstanding !== 5'd15) begin
            errors++;
            $display("FAIL max_resume wr=%b out=%0d exp 1 15", ph_wr_en, outstanding);
        end
        tick();
        req_empty    = '1;
        ph_out_empty = 1'b0;
        for (int k = 0; k < 16; k++) tick();
        ph_out_empty = 1'b1;
        mid();
        checks++;
        if (outstanding !== 5'd0) begin
            errors++;
            $display("FAIL max_drain got %0d exp 0", outstanding);
        end
        tick();
    endtask

    task automatic test_head_block();
        do_reset();
        req_empty = 4'b1011;
        mid();
        checks++;
        if (req_rd_en !== 4'b0100) begin
            errors++;
            $display("FAIL hol_issue2 got %b exp 0100", req_rd_en);
        end
        tick();
        req_empty = 4'b1110;
        mid();
        checks++;
        if (req_rd_en !== 4'b0001) begin
            errors++;
            $display("FAIL hol_issue0 got %b exp 0001", req_rd_en);
        end
        tick();
        req_empty    = '1;
        resp_full    = 4'b0100;
        ph_out_empty = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mid();
            checks++;
            if (ph_out_rd_en !== 1'b0 || resp_wr_en !== 4'b0000) begin
                errors++;
                $display("FAIL hol_stall%0d ordr=%b resp=%b exp 0 0000",
                         k, ph_out_rd_en, resp_wr_en);
            end
            tick();
        end
        resp_full = '0;
        mid();
        checks++;
        if (ph_out_rd_en !== 1'b1 || resp_wr_en !== 4'b0100) begin
            errors++;
            $display("FAIL hol_release ordr=%b resp=%b exp 1 0100", ph_out_rd_en, resp_wr_en);
        end
        tick();
        mid();
        checks++;
        if (resp_wr_en !== 4'b0001) begin
            errors++;
            $display("FAIL hol_next got %b exp 0001", resp_wr_en);
        end
        tick();
        ph_out_empty = 1'b1;
    endtask

    task automatic test_flush();
        do_reset();
        req_empty = 4'b1101;
        for (int k = 0; k < 5; k++) tick();
        flush = 1'b1;
        mid();
        checks++;
        if (ph_wr_en !== 1'b0 || outstanding !== 5'd5 || flush_done !== 1'b0) begin
            errors++;
            $display("FAIL flush_suppress wr=%b out=%0d fd=%b exp 0 5 0",
                     ph_wr_en, outstanding, flush_done);
        end
        tick();
        ph_out_empty = 1'b0;
        for (int k = 0; k < 5; k++) begin
            mid();
            checks++;
            if (ph_wr_en !== 1'b0 || flush_done !== 1'b0 || ph_out_rd_en !== 1'b1) begin
                errors++;
                $display("FAIL flush_drain%0d wr=%b fd=%b ordr=%b exp 0 0 1",
                         k, ph_wr_en, flush_done, ph_out_rd_en);
            end
            tick();
        end
        ph_out_empty = 1'b1;
        mid();
        checks++;
        if (flush_done !== 1'b1 || outstanding !== 5'd0) begin
            errors++;
            $display("FAIL flush_done fd=%b out=%0d exp 1 0", flush_done, outstanding);
        end
        tick();
        flush = 1'b0;
        mid();
        checks++;
        if (flush_done !== 1'b1 || ph_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL flush_done_hold fd=%b wr=%b exp 1 0", flush_done, ph_wr_en);
        end
        tick();
        mid();
        checks++;
        if (flush_done !== 1'b0 || ph_wr_en !== 1'b1 || req_rd_en !== 4'b0010) begin
            errors++;
            $display("FAIL flush_resume fd=%b wr=%b rd=%b exp 0 1 0010",
                     flush_done, ph_wr_en, req_rd_en);
        end
        tick();
        req_empty = '1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_stat;
`ifdef P_HIT_ARB_STATS_EN
        exp_stat = 32'd7;
`else
        exp_stat = 32'd0;
`endif
        do_reset();
        req_empty = 4'b0111;
        for (int k = 0; k < 7; k++) tick();
        req_empty = '1;
        mid();
        checks++;
        if (outstanding !== 5'd7 || stat_issued[3] !== exp_stat || stat_issued[1] !== 32'd0) begin
            errors++;
            $display("FAIL rmid_pre out=%0d stat3=%0d stat1=%0d exp 7 %0d 0",
                     outstanding, stat_issued[3], stat_issued[1], exp_stat);
        end
        tick();
        req_empty    = 4'b0111;
        ph_out_empty = 1'b0;
        mid();
        checks++;
        if (ph_wr_en !== 1'b1 || ph_out_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL rmid_active wr=%b ordr=%b exp 1 1", ph_wr_en, ph_out_rd_en);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (outstanding !== 5'd0 || ph_wr_en !== 1'b0 || req_rd_en !== 4'b0000 ||
            ph_out_rd_en !== 1'b0 || resp_wr_en !== 4'b0000 || flush_done !== 1'b0) begin
            errors++;
            $display("FAIL rmid_clear out=%0d wr=%b rd=%b ordr=%b resp=%b fd=%b exp all 0",
                     outstanding, ph_wr_en, req_rd_en, ph_out_rd_en, resp_wr_en, flush_done);
        end
        checks++;
        if (stat_issued[3] !== 32'd0 || ph_origin[0] !== 32'sd0) begin
            errors++;
            $display("FAIL rmid_regs stat3=%0d org=%0h exp 0 0", stat_issued[3], ph_origin[0]);
        end
        set_idle();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        set_idle();
        init_data();
        tick();
        test_reset();
        test_single();
        test_round_robin();
        test_max_out();
        test_head_block();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/p_hit_arb.md
P_HIT_ARB -- requirements
Module: p_hit_arb

Interface
REQ-001 The module SHALL have parameter D_BITS, default 32: data word width.
REQ-002 The module SHALL have parameter N_REQ, default 4: number of ray requesters (2..8).
REQ-003 The module SHALL have parameter MAX_OUT, default 16: maximum in-flight jobs (power of 2).
REQ-004 The module SHALL have these clock and reset ports, and the rest of its ports are listed in REQ-005 to REQ-009:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
REQ-005 The module SHALL have these request-side ports:
- req_empty  in  [N_REQ]  requester FIFO empty.
- req_rd_en  out  [N_REQ]  pop strobe to requester.
- req_origin  in  signed D_BITS [N_REQ][3]  ray origin.
- req_dir  in  signed D_BITS [N_REQ][3]  ray direction.
REQ-006 The module SHALL have these datapath-issue ports:
- ph_wr_en  out  1  write to the p_hit pipeline.
- ph_full  in  1  p_hit input full.
- ph_origin  out  signed D_BITS [3]  issued origin.
- ph_dir  out  signed D_BITS [3]  issued direction.
REQ-007 The module SHALL have these datapath-result ports:
- ph_out_empty  in  1  p_hit result empty.
- ph_out_rd_en  out  1  pop p_hit result.
- ph_p_hit  in  signed D_BITS [3]  hit point.
REQ-008 The module SHALL have these response-side ports:
- resp_wr_en  out  [N_REQ]  write to requester result FIFO.
- resp_full  in  [N_REQ]  requester result FIFO full.
- resp_p_hit  out  signed D_BITS [3]  routed hit point.
REQ-009 The module SHALL have these control and status ports:
- flush  in  1  stop issuing and drain.
- flush_done  out  1  drain complete.
- outstanding  out  $clog2(MAX_OUT)+1  in-flight count.
- stat_issued  out  32 [N_REQ]  per-requester issue count.

Function
REQ-010 The block SHALL arbitrate among requesters with req_empty=0 using round-robin, with priority starting at the index after the last grant (index 0 after reset).
REQ-011 An issue SHALL occur in the same cycle as the grant when state=RUN, some req_empty=0, ph_full=0, outstanding<MAX_OUT and tag FIFO not full.
REQ-012 On an issue, the block SHALL assert ph_wr_en and req_rd_en[g] for one cycle, drive ph_origin/ph_dir combinationally from requester g, and push tag g.
REQ-013 Zero-latency issue: the request presented at cycle t SHALL appear on ph_* at cycle t, with at most one issue per cycle.
REQ-014 When the block does not issue, ph_wr_en and all req_rd_en SHALL be 0, and ph_origin/ph_dir SHALL hold their last issued value.
REQ-015 Result routing: when ph_out_empty=0, the tag FIFO is non-empty with head tag h, and resp_full[h]=0, the block SHALL assert ph_out_rd_en, resp_wr_en[h] and pop the tag, with resp_p_hit = ph_p_hit in the same cycle.
REQ-016 If resp_full[h]=1, the block SHALL stall retirement; there SHALL be no reordering and no head-of-line bypass.
REQ-017 outstanding SHALL increment on issue, decrement on retire, and stay unchanged when both occur in one cycle.
REQ-018 outstanding SHALL never exceed MAX_OUT; at outstanding=MAX_OUT, issue SHALL be blocked while retire remains allowed.
REQ-019 The FSM SHALL have states RUN, DRAIN and DONE, with these transitions:
- RUN to DRAIN when flush=1.
- DRAIN to DONE when outstanding=0.
- DONE to RUN when flush=0.
REQ-020 No issue SHALL occur in DRAIN or DONE, while retirement SHALL continue in those states.
REQ-021 flush_done SHALL equal 1 exactly in DONE.
REQ-022 A flush asserted in the same cycle as an eligible issue SHALL suppress that issue.
REQ-023 An X or stale value on req_origin of a requester with req_empty=1 SHALL never propagate to ph_*.

Reset
REQ-024 While reset=0, the following SHALL be cleared asynchronously: state to RUN, round-robin pointer to 0, outstanding to 0, tag FIFO empty, ph_origin/ph_dir to 0, and stat_issued to 0.
REQ-025 While reset=0, ph_wr_en, ph_out_rd_en, req_rd_en, resp_wr_en and flush_done SHALL be 0.
REQ-026 Reset mid-operation SHALL discard all tags, and the environment SHALL reset the p_hit pipeline in the same reset.

Configuration
REQ-027 With macro P_HIT_ARB_STATS_EN defined, stat_issued[i] SHALL be a 32-bit wrapping counter of issues granted to requester i.
REQ-028 Without P_HIT_ARB_STATS_EN, stat_issued SHALL be a constant 0 and no counter flops SHALL be present.

Structure
REQ-029 Package p_hit_arb_pkg SHALL hold the FSM state enum (RUN, DRAIN, DONE) and the tag width function TAG_BITS=$clog2(N_REQ).
REQ-030 The tag FIFO SHALL be one sub-module, p_hit_tag_fifo: synchronous, MAX_OUT deep, TAG_BITS wide, with full/empty flags and first-word-fall-through output.

Verification
REQ-031 Single requester: req_empty[1]=0 for 3 jobs with origin (1.0,2.0,3.0) in Q16 (0x10000, 0x20000, 0x30000) -> 3 consecutive ph_wr_en, and 3 results routed to resp_wr_en[1] in order.
REQ-032 All 4 requesters continuously non-empty for 8 cycles -> grant sequence 0,1,2,3,0,1,2,3.
REQ-033 ph_out_empty held 1 with 20 jobs available -> exactly 16 issues, outstanding=16, and issue resumes within 1 cycle of the first retire.
REQ-034 resp_full[2]=1 with tag head 2 and results pending -> ph_out_rd_en=0 until resp_full[2]=0, then the retire occurs that cycle.
REQ-035 flush at outstanding=5 -> no further issues, flush_done=1 the cycle after the 5th retire, and RUN resumes after flush drops.
REQ-036 reset asserted with outstanding=7 -> outstanding=0, all strobes 0 immediately, with and without P_HIT_ARB_STATS_EN (stat_issued = 0 after reset).
